// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift/rotate unit: operation codes and
// controller state encoding.
package shift_pkg;

    // Operation encoding, identical to the combinational barrel shifter.
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// Combinational 16-bit shifter that moves the operand by one or two bit
// positions in the direction and with the fill selected by Op.
module shift_step
    import shift_pkg::*;
(
    input  logic [15:0] In,
    input  logic [1:0]  Op,
    input  logic        K2,
    output logic [15:0] Out
);

    // Select the 1- or 2-bit shifted image of the operand for the requested op.
    always_comb begin
        Out = In;
        if (K2) begin
            case (Op)
                OP_ROL:  Out = {In[13:0], In[15:14]};
                OP_SLL:  Out = {In[13:0], 2'b00};
                OP_SRA:  Out = {{2{In[15]}}, In[15:2]};
                OP_SRL:  Out = {2'b00, In[15:2]};
                default: Out = In;
            endcase
        end else begin
            case (Op)
                OP_ROL:  Out = {In[14:0], In[15]};
                OP_SLL:  Out = {In[14:0], 1'b0};
                OP_SRA:  Out = {In[15], In[15:1]};
                OP_SRL:  Out = {1'b0, In[15:1]};
                default: Out = In;
            endcase
        end
    end

endmodule : shift_step

// File: rtl/shift_iter_seq.sv
// Multi-cycle 16-bit shift/rotate unit. Accepts an operand, count and op on a
// Start handshake, then walks the shift at up to two bits per clock. Busy and
// Done are held in flops loaded from the next-state decode so they never
// depend combinationally on the inputs.
module shift_iter_seq
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [15:0] In,
    input  logic [3:0]  Cnt,
    input  logic [1:0]  Op,
    output logic [15:0] Out,
    output logic        Busy,
    output logic        Done
);

    state_e      state_r;
    state_e      state_next_s;
    logic [15:0] r_r;
    logic [15:0] r_next_s;
    logic [3:0]  rem_r;
    logic [3:0]  rem_next_s;
    logic [1:0]  opq_r;
    logic [1:0]  opq_next_s;
    logic        busy_r;
    logic        busy_next_s;
    logic        done_r;
    logic        done_next_s;
    logic        k2_s;
    logic [15:0] step_out_s;

    // Take a 2-bit step whenever at least two bits of shift remain.
    assign k2_s = (rem_r >= 4'd2);

    shift_step u_step (
        .In  (r_r),
        .Op  (opq_r),
        .K2  (k2_s),
        .Out (step_out_s)
    );

    // Next-state, datapath load/step and status decode for the controller.
    always_comb begin
        state_next_s = state_r;
        r_next_s     = r_r;
        rem_next_s   = rem_r;
        opq_next_s   = opq_r;
        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    r_next_s   = In;
                    rem_next_s = Cnt;
                    opq_next_s = Op;
                    if (Cnt != 4'd0) begin
                        state_next_s = ST_SHIFT;
                    end else begin
                        state_next_s = ST_DONE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                r_next_s = step_out_s;
                if (k2_s) begin
                    rem_next_s = rem_r - 4'd2;
                end else begin
                    rem_next_s = rem_r - 4'd1;
                end
                if (rem_next_s == 4'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
        done_next_s = (state_next_s == ST_DONE);
    end

    // State, datapath and status registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            r_r     <= 16'h0000;
            rem_r   <= 4'd0;
            opq_r   <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            r_r     <= r_next_s;
            rem_r   <= rem_next_s;
            opq_r   <= opq_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
        end
    end

    assign Out  = r_r;
    assign Busy = busy_r;
    assign Done = done_r;

endmodule : shift_iter_seq

// File: tb/tb_shift_iter_seq.sv
// Self-checking bench for shift_iter_seq: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_shift_iter_seq;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic [15:0] Out;
    logic        Busy;
    logic        Done;

    int n_checks;
    int n_errors;

    shift_iter_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .In    (In),
        .Cnt   (Cnt),
        .Op    (Op),
        .Out   (Out),
        .Busy  (Busy),
        .Done  (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result: rotate via a doubled word, shifts via SV operators.
    function automatic logic [15:0] ref_shift(input logic [15:0] x, input int c, input logic [1:0] op);
        logic [31:0]        dbl;
        logic signed [15:0] sx;
        sx = x;
        case (op)
            2'b00: begin
                dbl = {x, x} << c;
                return dbl[31:16];
            end
            2'b01:   return x << c;
            2'b10:   return sx >>> c;
            default: return x >> c;
        endcase
    endfunction

    // Issue one operation; check latency, result and handshake.
    // inject=1 pulses Start with junk operands during SHIFT and in the DONE cycle.
    task automatic run_op(input logic [15:0] a, input logic [3:0] c, input logic [1:0] op,
                          input logic [15:0] exp_out, input bit inject, input string tag);
        int n;
        int exp_lat;
        exp_lat = (int'(c) + 1) / 2;
        Start = 1'b1; In = a; Cnt = c; Op = op;
        @(posedge clk); #1;
        Start = 1'b0;
        In = 16'($urandom); Cnt = 4'($urandom); Op = 2'($urandom);
        check_val({tag, "_busy_acc"}, 32'(Busy), 32'd1);
        n = 0;
        while (!Done && n < 20) begin
            if (inject && n == 1) begin
                Start = 1'b1; In = 16'($urandom); Cnt = 4'd1; Op = 2'($urandom);
            end else begin
                Start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        Start = 1'b0;
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_val({tag, "_out"}, 32'(Out), 32'(exp_out));
        check_val({tag, "_busy_done"}, 32'(Busy), 32'd1);
        if (inject) begin
            Start = 1'b1; In = 16'hFFFF; Cnt = 4'd15; Op = 2'b01;
        end
        @(posedge clk); #1;
        Start = 1'b0;
        check_val({tag, "_busy_after"}, 32'(Busy), 32'd0);
        check_val({tag, "_done_after"}, 32'(Done), 32'd0);
        if (inject) begin
            check_val({tag, "_out_held"}, 32'(Out), 32'(exp_out));
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [3:0]  c;
        logic [1:0]  op;
        int          done_seen;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; Start = 1'b0; In = 16'h0000; Cnt = 4'd0; Op = 2'b00;
        #12;
        check_val("rst_out", 32'(Out), 32'd0);
        check_val("rst_busy", 32'(Busy), 32'd0);
        check_val("rst_done", 32'(Done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("idle_busy", 32'(Busy), 32'd0);

        run_op(16'h8001, 4'd4,  2'b00, 16'h0018, 1'b0, "rol");
        run_op(16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, "sra15");
        run_op(16'hF00F, 4'd3,  2'b11, 16'h1E01, 1'b0, "srl3");
        run_op(16'h1234, 4'd0,  2'b01, 16'h1234, 1'b0, "cnt0");
        run_op(16'hC001, 4'd1,  2'b01, 16'h8002, 1'b0, "sll1");

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_out", 32'(Out), 32'd0);
        check_val("async_rst_busy", 32'(Busy), 32'd0);
        check_val("async_rst_done", 32'(Done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Start ignored while busy, result unaffected.
        run_op(16'hA5C3, 4'd9, 2'b00, ref_shift(16'hA5C3, 9, 2'b00), 1'b1, "ignore");

        // Reset in the middle of a SHIFT sequence.
        Start = 1'b1; In = 16'h8000; Cnt = 4'd15; Op = 2'b10;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out", 32'(Out), 32'd0);
        check_val("mid_rst_busy", 32'(Busy), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (Done) done_seen++;
        end
        check_val("mid_rst_no_done", 32'(done_seen), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0F0F, 4'd6, 2'b11, 16'h003C, 1'b0, "post_rst");

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            a  = 16'($urandom);
            c  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            run_op(a, c, op, ref_shift(a, int'(c), op), 1'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_shift_iter_seq

// File: doc/shift_iter_seq.md
# shift_iter_seq

Multi-cycle 16-bit shift/rotate unit that applies a 0–15 bit shift in steps of at most 2 bits per clock. It uses the same four-op shift encoding as the combinational barrel shifter. It serves paths that trade latency for area and accept work through a Start/Busy/Done handshake. It is the sequential counterpart to the single-cycle shifter rows in the ALU datapath.

## Interface
- No parameters; data width is fixed at 16 and shift count at 4 bits.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- In  input  16  operand, captured on the accepting edge.
- Cnt  input  4  shift amount 0–15, captured on the accepting edge.
- Op  input  2  operation, captured on the accepting edge:
  - 00 rotate left
  - 01 shift left logical
  - 10 shift right arithmetic
  - 11 shift right logical
- Out  output  16  result register; valid when Done=1; held until the next accepted Start.
- Busy  output  1  high from the accepting edge until the edge after Done.
- Done  output  1  one-cycle pulse marking a valid result.

## Operation
- States:
  - IDLE
  - SHIFT
  - DONE
- Internal registers:
  - R[15:0], drives Out.
  - Rem[3:0], remaining count.
  - OpQ[1:0], latched operation.
- IDLE with Start=1 (the accepting edge):
  - Load R=In, Rem=Cnt, OpQ=Op.
  - Next state is SHIFT if Cnt≠0, otherwise DONE.
- SHIFT, each edge:
  - Step size k=2 if Rem≥2, else k=1.
  - R = step(R, OpQ, k); Rem = Rem−k.
  - Go to DONE when the new Rem=0.
- Step semantics for k bits:
  - Rotate left: vacated LSBs take the old top k bits.
  - Shift left logical: zero fill.
  - Shift right arithmetic: R[15] fill.
  - Shift right logical: zero fill.
- DONE:
  - Done=1 and Busy=1 for exactly one cycle.
  - Next edge returns to IDLE.
- Start while Busy=1 (SHIFT or DONE) is ignored; no queuing.
- Out shows intermediate values during SHIFT. Consumers sample it only on Done.
- Reset is asynchronous and takes effect at any time, including mid-operation. It forces:
  - state=IDLE
  - R=16'h0000, Rem=0, OpQ=00
  - Out=16'h0000, Busy=0, Done=0
  - The in-flight operation is aborted; no Done is produced.

## Timing
- Done asserts after ceil(Cnt/2) edges following the accepting edge.
  - Cnt=0: Done is high in the cycle right after the accepting edge.
  - Cnt=15: Done follows 8 SHIFT edges.
- The earliest next accept is the edge after the DONE cycle, so back-to-back throughput is 1 op per ceil(Cnt/2)+2 cycles.
- Busy and Done are decoded from the state register (glitch-free, no combinational path from inputs).
- Out is a register output with no combinational path from In.

## Structure
- Package shift_pkg holds:
  - Op encoding constants (OP_ROL=2'b00, OP_SLL=2'b01, OP_SRA=2'b10, OP_SRL=2'b11).
  - State encoding (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module shift_step: combinational 16-bit, 1-or-2-bit shifter with ports In, Op, K2 (1 selects a 2-bit step), Out.
- The top level contains only the state machine, the Rem counter and the R/OpQ registers.

## Test plan
- Reset: assert rst_n=0 mid-cycle → Out=16'h0000, Busy=0, Done=0 immediately, without waiting for a clock edge.
- Rotate left: In=16'h8001, Cnt=4, Op=00 → Done on the 2nd edge after accept, Out=16'h0018.
- Arithmetic right: In=16'h8000, Cnt=15, Op=10 → 8 SHIFT edges (steps 2,2,2,2,2,2,2,1), Out=16'hFFFF.
- Logical right: In=16'hF00F, Cnt=3, Op=11 → Done after 2 edges, Out=16'h1E01.
- Zero count: In=16'h1234, Cnt=0, Op=01 → Done in the cycle after accept, Out=16'h1234.
  - Follow-up: In=16'hC001, Cnt=1, Op=01 → Out=16'h8002.
- Ignored start and mid-operation reset:
  - Pulse Start with new operands during SHIFT → result unaffected.
  - Assert rst_n=0 during SHIFT → no Done is produced; all outputs read zero.
  - After releasing reset, a fresh Start completes normally.
